// File: rtl/csa_sub_pipe.sv
// csa_sub_pipe: two-stage pipelined carry-select subtractor, DIFF = A - B.
// Stage 1 resolves the low segment and both upper-segment candidates.
// Stage 2 selects the upper candidate with the registered low carry and
// forms the flags. Valid/ready handshake on both sides, one valid bit per stage.
module csa_sub_pipe #(
   parameter int WIDTH = 10,
   parameter int LOW_W = WIDTH / 2
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [WIDTH-1:0] DIFF,
   output logic             BORROW,
   output logic             ZERO,
   output logic             OVF
);

   localparam int HI_W = WIDTH - LOW_W;

   // stage 1 registers
   logic             s1_v_q, s1_v_d;
   logic [LOW_W-1:0] s1_low_q;
   logic             s1_clow_q;
   logic [HI_W:0]    s1_hi0_q, s1_hi1_q;
   logic             s1_amsb_q, s1_bmsb_q;

   // stage 2 registers
   logic             s2_v_q, s2_v_d;
   logic [WIDTH-1:0] s2_diff_q;
   logic             s2_borrow_q, s2_zero_q, s2_ovf_q;

   // stage 1 combinational results
   logic [WIDTH-1:0] b_inv;
   logic [LOW_W:0]   low_d;
   logic [HI_W:0]    hi0_d, hi1_d;

   // stage 2 combinational results
   logic [HI_W:0]    hi_sel;
   logic [WIDTH-1:0] diff_d;
   logic             borrow_d, zero_d, ovf_d;

   logic             s1_load, s2_load;

   // Handshake: stage 2 refills when empty or draining; stage 1 accepts when
   // it is empty or its contents move on this cycle.
   always_comb begin
      s2_load  = s1_v_q & (~s2_v_q | OUT_READY);
      IN_READY = ~s1_v_q | s2_load;
      s1_load  = IN_VALID & IN_READY;

      s1_v_d = s1_v_q;
      if (s1_load)      s1_v_d = 1'b1;
      else if (s2_load) s1_v_d = 1'b0;

      s2_v_d = s2_v_q;
      if (s2_load)                   s2_v_d = 1'b1;
      else if (OUT_READY & s2_v_q)   s2_v_d = 1'b0;
   end

   // Stage 1 arithmetic: A + ~B + 1 split into a low segment (carry-in 1) and
   // two speculative upper segments (carry-in 0 and 1) evaluated in parallel.
   always_comb begin
      b_inv = ~B;
      low_d = {1'b0, A[LOW_W-1:0]} + {1'b0, b_inv[LOW_W-1:0]}
              + {{LOW_W{1'b0}}, 1'b1};
      hi0_d = {1'b0, A[WIDTH-1:LOW_W]} + {1'b0, b_inv[WIDTH-1:LOW_W]};
      hi1_d = {1'b0, A[WIDTH-1:LOW_W]} + {1'b0, b_inv[WIDTH-1:LOW_W]}
              + {{HI_W{1'b0}}, 1'b1};
   end

   // Stage 2 select and flags from the registered stage-1 values only.
   always_comb begin
      hi_sel   = s1_clow_q ? s1_hi1_q : s1_hi0_q;
      diff_d   = {hi_sel[HI_W-1:0], s1_low_q};
      borrow_d = ~hi_sel[HI_W];
      zero_d   = ~|diff_d;
      ovf_d    = (s1_amsb_q ^ s1_bmsb_q) & (diff_d[WIDTH-1] ^ s1_amsb_q);
   end

   // Stage 1 registers: load only on accept, hold while stalled.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         s1_v_q    <= 1'b0;
         s1_low_q  <= '0;
         s1_clow_q <= 1'b0;
         s1_hi0_q  <= '0;
         s1_hi1_q  <= '0;
         s1_amsb_q <= 1'b0;
         s1_bmsb_q <= 1'b0;
      end else begin
         s1_v_q <= s1_v_d;
         if (s1_load) begin
            s1_low_q  <= low_d[LOW_W-1:0];
            s1_clow_q <= low_d[LOW_W];
            s1_hi0_q  <= hi0_d;
            s1_hi1_q  <= hi1_d;
            s1_amsb_q <= A[WIDTH-1];
            s1_bmsb_q <= B[WIDTH-1];
         end
      end
   end

   // Stage 2 registers: load only on advance, hold while the consumer stalls.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         s2_v_q      <= 1'b0;
         s2_diff_q   <= '0;
         s2_borrow_q <= 1'b0;
         s2_zero_q   <= 1'b0;
         s2_ovf_q    <= 1'b0;
      end else begin
         s2_v_q <= s2_v_d;
         if (s2_load) begin
            s2_diff_q   <= diff_d;
            s2_borrow_q <= borrow_d;
            s2_zero_q   <= zero_d;
            s2_ovf_q    <= ovf_d;
         end
      end
   end

   assign OUT_VALID = s2_v_q;
   assign DIFF      = s2_diff_q;
   assign BORROW    = s2_borrow_q;
   assign ZERO      = s2_zero_q;
   assign OVF       = s2_ovf_q;

endmodule

// File: tb/tb_csa_sub_pipe.sv
// tb_csa_sub_pipe: directed and randomized stimulus for csa_sub_pipe with a
// queue-based scoreboard holding an arithmetic reference model.
module tb_csa_sub_pipe;

   localparam int W = 10;

   logic         CLK = 1'b0;
   logic         RST;
   logic         IN_VALID;
   logic         IN_READY;
   logic [W-1:0] A, B;
   logic         OUT_VALID;
   logic         OUT_READY;
   logic [W-1:0] DIFF;
   logic         BORROW, ZERO, OVF;

   int n_tests = 0;
   int n_fail  = 0;
   int n_out   = 0;
   bit rnd_rdy = 1'b0;

   typedef struct packed {
      logic [W-1:0] a;
      logic [W-1:0] b;
   } op_t;

   op_t q[$];

   csa_sub_pipe #(.WIDTH(W)) dut (
      .CLK(CLK), .RST(RST),
      .IN_VALID(IN_VALID), .IN_READY(IN_READY),
      .A(A), .B(B),
      .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
      .DIFF(DIFF), .BORROW(BORROW), .ZERO(ZERO), .OVF(OVF)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer subtraction and range check of the signed result.
   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] d, output logic br,
                                 output logic z, output logic ov);
      int sd;
      d  = a - b;
      br = (a < b);
      z  = (d == '0);
      sd = int'($signed(a)) - int'($signed(b));
      ov = (sd > (1 << (W-1)) - 1) || (sd < -(1 << (W-1)));
   endfunction

   // Scoreboard: handshakes sampled mid-cycle, where the next edge will see them.
   always @(negedge CLK) begin
      op_t          op;
      logic [W-1:0] ed;
      logic         eb, ez, eo;
      if (!RST) begin
         if (OUT_VALID && OUT_READY) begin
            if (q.size() == 0) begin
               check("spurious_out", 1, 0);
            end else begin
               op = q.pop_front();
               model(op.a, op.b, ed, eb, ez, eo);
               check("diff", DIFF, ed);
               check("borrow", BORROW, eb);
               check("zero", ZERO, ez);
               check("ovf", OVF, eo);
               n_out++;
            end
         end
         if (IN_VALID && IN_READY) q.push_back('{a: A, b: B});
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
      if (rnd_rdy) OUT_READY = ($urandom_range(0, 3) != 0);
   endtask

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
      bit ok = 1'b0;
      A = a;
      B = b;
      IN_VALID = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge CLK);
         if (IN_READY) ok = 1'b1;
         step();
         if (ok) break;
      end
      IN_VALID = 1'b0;
      if (!ok) check("send_timeout", 0, 1);
   endtask

   task automatic drain();
      OUT_READY = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if (q.size() == 0) break;
         step();
      end
      check("drain_empty", q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int base;
      logic [W-1:0] ra, rb;
      RST = 1'b1;
      IN_VALID = 1'b0;
      OUT_READY = 1'b0;
      A = '0;
      B = '0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      check("rst_out_valid", OUT_VALID, 0);
      check("rst_diff", DIFF, 0);
      check("rst_borrow", BORROW, 0);
      check("rst_zero", ZERO, 0);
      check("rst_ovf", OVF, 0);
      check("rst_in_ready", IN_READY, 1);
      @(posedge CLK);
      #1;
      RST = 1'b0;
      OUT_READY = 1'b1;

      // latency: accept at edge N, result visible after edge N+1
      A = 10'd5;
      B = 10'd3;
      IN_VALID = 1'b1;
      @(negedge CLK);
      check("lat_in_ready", IN_READY, 1);
      @(posedge CLK);
      #1;
      IN_VALID = 1'b0;
      @(negedge CLK);
      check("lat_not_yet", OUT_VALID, 0);
      @(negedge CLK);
      check("lat_out_valid", OUT_VALID, 1);
      check("lat_diff", DIFF, 10'd2);
      step();

      // directed corners
      send(10'd3, 10'd5);
      send(10'h200, 10'h001);
      send(10'd7, 10'd7);
      send(10'h020, 10'h001);
      send(10'h155, 10'h000);
      send(10'h3FF, 10'h3FF);
      drain();

      // backpressure: two accepts fill the pipe, third waits at the input
      base = n_out;
      OUT_READY = 1'b0;
      send(10'd10, 10'd1);
      send(10'd20, 10'd2);
      A = 10'd30;
      B = 10'd3;
      IN_VALID = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         check("bp_in_ready", IN_READY, 0);
         check("bp_out_valid", OUT_VALID, 1);
         check("bp_diff_hold", DIFF, 10'd9);
         step();
      end
      OUT_READY = 1'b1;
      send(10'd30, 10'd3);
      drain();
      check("bp_count", n_out - base, 3);

      // randomized traffic with random consumer stalls
      base = n_out;
      rnd_rdy = 1'b1;
      for (int i = 0; i < 300; i++) begin
         ra = W'($urandom_range(0, (1 << W) - 1));
         case ($urandom_range(0, 7))
            0:       rb = ra;
            1:       rb = '0;
            default: rb = W'($urandom_range(0, (1 << W) - 1));
         endcase
         if ($urandom_range(0, 3) == 0) step();
         send(ra, rb);
      end
      rnd_rdy = 1'b0;
      drain();
      check("rnd_count", n_out - base, 300);

      // reset with both stages occupied
      OUT_READY = 1'b0;
      send(10'd100, 10'd1);
      send(10'd200, 10'd2);
      @(negedge CLK);
      check("mid_pre_valid", OUT_VALID, 1);
      check("mid_pre_in_ready", IN_READY, 0);
      #2;
      RST = 1'b1;
      #1;
      check("mid_out_valid", OUT_VALID, 0);
      check("mid_diff", DIFF, 0);
      check("mid_borrow", BORROW, 0);
      check("mid_zero", ZERO, 0);
      check("mid_ovf", OVF, 0);
      check("mid_in_ready", IN_READY, 1);
      q.delete();
      @(posedge CLK);
      #1;
      RST = 1'b0;
      OUT_READY = 1'b1;
      base = n_out;
      send(10'd1, 10'd2);
      drain();
      check("post_rst_count", n_out - base, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
